// File: rtl/lcd_bus_arbiter_if.sv
// Requester-side bus of the LCD arbiter: level requests in, ack/busy out.
interface lcd_bus_arbiter_if;
   logic [1:0] req;
   logic [1:0] req_rs;
   logic [7:0] req_data0;
   logic [7:0] req_data1;
   logic [1:0] ack;
   logic       busy;

   modport master (
      output req, req_rs, req_data0, req_data1,
      input  ack, busy
   );

   modport slave (
      input  req, req_rs, req_data0, req_data1,
      output ack, busy
   );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Two-requester HD44780 4-bit bus arbiter with nibble strobes and settle delay.
// Define LCD_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority.
module lcd_bus_arbiter #(
   parameter int unsigned EN_HIGH_CYCLES    = 1,
   parameter int unsigned NIBBLE_GAP_CYCLES = 1,
   parameter int unsigned CMD_DELAY_CYCLES  = 1,
   parameter int unsigned LONG_DELAY_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   lcd_bus_arbiter_if.slave bus,
   output logic             o_lcd_en,
   output logic             o_lcd_rs,
   output logic [3:0]       o_lcd_data
);

   // Counter reload values; a zero parameter behaves as one cycle.
   localparam logic [7:0] LP_EN = (EN_HIGH_CYCLES == 0) ?
      8'd0 : 8'(EN_HIGH_CYCLES - 1);
   localparam logic [7:0] LP_GAP = (NIBBLE_GAP_CYCLES == 0) ?
      8'd0 : 8'(NIBBLE_GAP_CYCLES - 1);
   localparam logic [7:0] LP_CMD = (CMD_DELAY_CYCLES == 0) ?
      8'd0 : 8'(CMD_DELAY_CYCLES - 1);
   localparam logic [7:0] LP_LONG = (LONG_DELAY_CYCLES == 0) ?
      8'd0 : 8'(LONG_DELAY_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HI_EN,
      S_HI_GAP,
      S_LO_EN,
      S_SETTLE
   } state_t;

   state_t     r_state;
   logic [7:0] r_cnt;
   logic [7:0] r_byte;
   logic [1:0] r_ack;
   logic       r_busy;
   logic       r_en;
   logic       r_rs;
   logic [3:0] r_data;

   logic       w_gnt;
   logic       w_rs;
   logic [7:0] w_byte;
   logic       w_done;
   logic       w_long;

`ifdef LCD_ARB_ROUND_ROBIN_EN
   logic r_last;

   always_comb begin
      w_gnt = bus.req[1];
      if (&bus.req)
         w_gnt = ~r_last;
   end

   // Reset value 1 lets req0 win the first tie.
   always_ff @(posedge clk) begin
      if (reset)
         r_last <= 1'b1;
      else if (r_state == S_IDLE && |bus.req)
         r_last <= w_gnt;
   end
`else
   assign w_gnt = ~bus.req[0];
`endif

   assign w_byte = w_gnt ? bus.req_data1 : bus.req_data0;
   assign w_rs   = bus.req_rs[w_gnt];
   assign w_done = (r_cnt == 8'd0);
   // Clear display / return home need the long settle.
   assign w_long = ~r_rs && (r_byte[7:2] == 6'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_byte  <= 8'd0;
         r_ack   <= 2'b00;
         r_busy  <= 1'b0;
         r_en    <= 1'b0;
         r_rs    <= 1'b0;
         r_data  <= 4'd0;
      end else begin
         r_ack <= 2'b00;
         if (!w_done)
            r_cnt <= r_cnt - 8'd1;
         unique case (r_state)
            S_IDLE: begin
               if (|bus.req) begin
                  r_state <= S_HI_EN;
                  r_byte  <= w_byte;
                  r_rs    <= w_rs;
                  r_data  <= w_byte[7:4];
                  r_en    <= 1'b1;
                  r_busy  <= 1'b1;
                  r_cnt   <= LP_EN;
                  r_ack   <= w_gnt ? 2'b10 : 2'b01;
               end
            end
            S_HI_EN: begin
               if (w_done) begin
                  r_state <= S_HI_GAP;
                  r_en    <= 1'b0;
                  r_cnt   <= LP_GAP;
               end
            end
            S_HI_GAP: begin
               if (w_done) begin
                  r_state <= S_LO_EN;
                  r_en    <= 1'b1;
                  r_data  <= r_byte[3:0];
                  r_cnt   <= LP_EN;
               end
            end
            S_LO_EN: begin
               if (w_done) begin
                  r_state <= S_SETTLE;
                  r_en    <= 1'b0;
                  r_cnt   <= w_long ? LP_LONG : LP_CMD;
               end
            end
            S_SETTLE: begin
               if (w_done) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_en    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ack    = r_ack;
   assign bus.busy   = r_busy;
   assign o_lcd_en   = r_en;
   assign o_lcd_rs   = r_rs;
   assign o_lcd_data = r_data;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: per-cycle trace model plus directed scenarios.
// Model follows LCD_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_lcd_bus_arbiter;

   localparam int P_EN   = 1;
   localparam int P_GAP  = 1;
   localparam int P_CMD  = 1;
   localparam int P_LONG = 2;

   logic       clk;
   logic       reset;
   logic       lcd_en;
   logic       lcd_rs;
   logic [3:0] lcd_data;
   logic       lcd_en_p;
   logic       lcd_rs_p;
   logic [3:0] lcd_data_p;

   int n_vec;
   int n_err;

   lcd_bus_arbiter_if bus();
   lcd_bus_arbiter_if bus_p();

   lcd_bus_arbiter u_dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .o_lcd_en   (lcd_en),
      .o_lcd_rs   (lcd_rs),
      .o_lcd_data (lcd_data)
   );

   lcd_bus_arbiter #(
      .EN_HIGH_CYCLES    (3),
      .NIBBLE_GAP_CYCLES (0),
      .CMD_DELAY_CYCLES  (2),
      .LONG_DELAY_CYCLES (4)
   ) u_par (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus_p),
      .o_lcd_en   (lcd_en_p),
      .o_lcd_rs   (lcd_rs_p),
      .o_lcd_data (lcd_data_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       en;
      logic       rs;
      logic [3:0] d;
      logic       busy;
      logic [1:0] ack;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   logic m_last;

   function automatic exp_t mk(input logic en, input logic rs,
                               input logic [3:0] d, input logic [1:0] ack);
      exp_t e;
      e.en   = en;
      e.rs   = rs;
      e.d    = d;
      e.busy = 1'b1;
      e.ack  = ack;
      return e;
   endfunction

   // Whole transfer as a list of per-cycle expectations.
   task automatic push_xfer(input logic g, input logic rs,
                            input logic [7:0] b);
      int s;
      logic [1:0] a;
      s = (!rs && b < 8'h04) ? P_LONG : P_CMD;
      a = g ? 2'b10 : 2'b01;
      for (int i = 0; i < P_EN; i++)
         q.push_back(mk(1'b1, rs, b[7:4], (i == 0) ? a : 2'b00));
      for (int i = 0; i < P_GAP; i++)
         q.push_back(mk(1'b0, rs, b[7:4], 2'b00));
      for (int i = 0; i < P_EN; i++)
         q.push_back(mk(1'b1, rs, b[3:0], 2'b00));
      for (int i = 0; i < s; i++)
         q.push_back(mk(1'b0, rs, b[3:0], 2'b00));
   endtask

   // One clock: model update and compare of the main DUT.
   task automatic cycle();
      logic       rst;
      logic [1:0] r;
      logic       g;
      rst = reset;
      r   = bus.req;
      g   = 1'b0;
      if (!rst && !cur.busy && r != 2'b00) begin
`ifdef LCD_ARB_ROUND_ROBIN_EN
         g = (r == 2'b11) ? ~m_last : r[1];
`else
         g = ~r[0];
`endif
         m_last = g;
         push_xfer(g, bus.req_rs[g],
                   g ? bus.req_data1 : bus.req_data0);
      end
      @(posedge clk);
      #1;
      if (rst) begin
         q.delete();
         cur    = '0;
         m_last = 1'b1;
      end else if (q.size() > 0) begin
         cur = q.pop_front();
      end else begin
         cur.en   = 1'b0;
         cur.busy = 1'b0;
         cur.ack  = 2'b00;
      end
      n_vec++;
      if ({lcd_en, lcd_rs, lcd_data, bus.busy, bus.ack} !== cur) begin
         n_err++;
         $display("FAIL cycle t=%0t got en%b rs%b d%h busy%b ack%b exp en%b rs%b d%h busy%b ack%b",
                  $time, lcd_en, lcd_rs, lcd_data, bus.busy, bus.ack,
                  cur.en, cur.rs, cur.d, cur.busy, cur.ack);
      end
   endtask

   function automatic logic [7:0] rnd_byte();
      if ($urandom_range(0, 3) == 0)
         return 8'($urandom_range(0, 3));
      return 8'($urandom);
   endfunction

   task automatic drain();
      bus.req = 2'b00;
      for (int i = 0; i < 10; i++)
         cycle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycle();
      cycle();
      n_vec++;
      if ({lcd_en, lcd_rs, lcd_data, bus.busy, bus.ack} !== 9'd0) begin
         n_err++;
         $display("FAIL reset_state got %b exp 0",
                  {lcd_en, lcd_rs, lcd_data, bus.busy, bus.ack});
      end
      reset = 1'b0;
      cycle();
   endtask

   task automatic run_directed(input logic g, input logic rs,
                               input logic [7:0] b, input string nm);
      logic [4:0] en_e;
      int len;
      len = (!rs && b < 8'h04) ? 6 : 5;
      en_e = 5'b00101;
      if (g) begin
         bus.req_data1 = b;
         bus.req_rs[1] = rs;
      end else begin
         bus.req_data0 = b;
         bus.req_rs[0] = rs;
      end
      bus.req[g] = 1'b1;
      for (int c = 1; c <= len; c++) begin
         cycle();
         if (c == 1) begin
            bus.req[g] = 1'b0;
            n_vec++;
            if (bus.ack !== (g ? 2'b10 : 2'b01)) begin
               n_err++;
               $display("FAIL %s_ack got %b", nm, bus.ack);
            end
         end
         n_vec++;
         if (lcd_en !== (c <= 5 && en_e[c-1]) ||
             bus.busy !== (c < len) ||
             lcd_data !== ((c <= 2) ? b[7:4] : b[3:0]) ||
             lcd_rs !== rs) begin
            n_err++;
            $display("FAIL %s_c%0d got en%b busy%b d%h rs%b",
                     nm, c, lcd_en, bus.busy, lcd_data, lcd_rs);
         end
      end
   endtask

   task automatic test_single();
      run_directed(1'b0, 1'b0, 8'h28, "single");
   endtask

   task automatic test_long_delay();
      run_directed(1'b1, 1'b0, 8'h01, "long");
      run_directed(1'b1, 1'b1, 8'h01, "data01");
      run_directed(1'b0, 1'b0, 8'h03, "home");
      run_directed(1'b0, 1'b0, 8'h04, "short04");
   endtask

   task automatic test_tie();
      logic [3:0] gs;
      logic [3:0] ex;
      int n;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      n = 0;
      gs = 4'b0;
      bus.req_data0 = rnd_byte();
      bus.req_data1 = rnd_byte();
      bus.req = 2'b11;
      for (int c = 0; c < 60 && n < 4; c++) begin
         cycle();
         if (bus.ack != 2'b00) begin
            gs[n] = bus.ack[1];
            n++;
            if (bus.ack[0]) bus.req_data0 = rnd_byte();
            if (bus.ack[1]) bus.req_data1 = rnd_byte();
         end
      end
`ifdef LCD_ARB_ROUND_ROBIN_EN
      ex = 4'b1010;
`else
      ex = 4'b0000;
`endif
      n_vec++;
      if (n != 4 || gs !== ex) begin
         n_err++;
         $display("FAIL tie grants=%0d got %b exp %b", n, gs, ex);
      end
      drain();
   endtask

   task automatic test_held_off();
      int c1;
      c1 = 0;
      bus.req_rs = 2'b11;
      bus.req_data0 = 8'h41;
      bus.req = 2'b01;
      cycle();
      bus.req = 2'b00;
      cycle();
      bus.req_data1 = 8'h42;
      bus.req = 2'b10;
      for (int c = 3; c < 20 && c1 == 0; c++) begin
         cycle();
         if (bus.ack != 2'b00) begin
            c1 = c;
            bus.req = 2'b00;
         end
      end
      n_vec++;
      if (c1 != 6) begin
         n_err++;
         $display("FAIL held_off ack_cycle got %0d exp 6", c1);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      bus.req_rs = 2'b00;
      bus.req_data0 = 8'h28;
      bus.req = 2'b01;
      cycle();
      bus.req = 2'b00;
      cycle();
      cycle();
      reset = 1'b1;
      bus.req = 2'b01;
      cycle();
      n_vec++;
      if ({lcd_en, lcd_data, bus.busy, bus.ack} !== 8'd0) begin
         n_err++;
         $display("FAIL reset_mid got %b exp 0",
                  {lcd_en, lcd_data, bus.busy, bus.ack});
      end
      reset = 1'b0;
      bus.req = 2'b00;
      bus.req_rs = 2'b10;
      bus.req_data1 = 8'h35;
      bus.req[1] = 1'b1;
      cycle();
      bus.req = 2'b00;
      n_vec++;
      if (bus.ack !== 2'b10 || lcd_en !== 1'b1 || lcd_data !== 4'h3) begin
         n_err++;
         $display("FAIL reset_new got ack%b en%b d%h exp 10 1 3",
                  bus.ack, lcd_en, lcd_data);
      end
      drain();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         cycle();
         for (int i = 0; i < 2; i++) begin
            if (cur.ack[i]) begin
               bus.req[i] = $urandom_range(0, 1) != 0;
            end
            if (cur.ack[i] || !bus.req[i]) begin
               if (!bus.req[i])
                  bus.req[i] = $urandom_range(0, 2) == 0;
               bus.req_rs[i] = $urandom_range(0, 1) != 0;
               if (i == 0) bus.req_data0 = rnd_byte();
               else        bus.req_data1 = rnd_byte();
            end
         end
      end
      drain();
   endtask

   task automatic test_params();
      int e;
      int g;
      int s;
      logic en_x;
      logic busy_x;
      logic [3:0] d_x;
      e = 3;
      g = 1;
      s = 2;
      bus_p.req_rs = 2'b01;
      bus_p.req_data0 = 8'h5A;
      bus_p.req = 2'b01;
      for (int c = 1; c <= 2*e + g + s + 1; c++) begin
         cycle();
         if (c == 1) begin
            bus_p.req = 2'b00;
            n_vec++;
            if (bus_p.ack !== 2'b01) begin
               n_err++;
               $display("FAIL par_ack got %b exp 01", bus_p.ack);
            end
         end
         en_x   = (c <= e) || (c > e + g && c <= 2*e + g);
         busy_x = c <= 2*e + g + s;
         d_x    = (c <= e + g) ? 4'h5 : 4'hA;
         n_vec++;
         if (lcd_en_p !== en_x || bus_p.busy !== busy_x ||
             lcd_data_p !== d_x || lcd_rs_p !== 1'b1) begin
            n_err++;
            $display("FAIL par_c%0d got en%b busy%b d%h exp en%b busy%b d%h",
                     c, lcd_en_p, bus_p.busy, lcd_data_p,
                     en_x, busy_x, d_x);
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      cur = '0;
      m_last = 1'b1;
      reset = 1'b1;
      bus.req = 2'b00;
      bus.req_rs = 2'b00;
      bus.req_data0 = 8'h00;
      bus.req_data1 = 8'h00;
      bus_p.req = 2'b00;
      bus_p.req_rs = 2'b00;
      bus_p.req_data0 = 8'h00;
      bus_p.req_data1 = 8'h00;
      test_reset();
      test_single();
      test_long_delay();
      test_tie();
      test_held_off();
      test_reset_mid();
      test_random();
      test_params();
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
